// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_ctrl
// Purpose  : Fetch sequencer for a 1-cycle synchronous instruction memory with
//            a small output FIFO, valid/ready delivery and redirect flush.
//            Optional FETCH_MISALIGN_TRAP_EN adds o_Misalign and a HALT state.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_ctrl #(
    parameter int                  MEM_ADDR_WIDTH = 10,
    parameter int                  INST_WIDTH     = 32,
    parameter int                  PC_WIDTH       = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC       = '0,
    parameter int                  FIFO_DEPTH     = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    output logic [MEM_ADDR_WIDTH-1:0] o_Mem_Addr,
    output logic                      o_Mem_Req,
    input  logic [INST_WIDTH-1:0]     i_Mem_Data,
    input  logic                      i_Redirect,
    input  logic [PC_WIDTH-1:0]       i_Redirect_PC,
    output logic                      o_Inst_Valid,
    input  logic                      i_Inst_Ready,
    output logic [INST_WIDTH-1:0]     o_Inst,
    output logic [PC_WIDTH-1:0]       o_Inst_PC
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic                      o_Misalign
`endif
);

    localparam int                 c_PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                 c_CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST   = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [c_CNT_W:0]   c_CREDIT_MAX = (c_CNT_W + 1)'(FIFO_DEPTH);

    logic [PC_WIDTH-1:0]   r_pc;
    logic                  r_data_v;
    logic [PC_WIDTH-1:0]   r_data_pc;
    logic [INST_WIDTH-1:0] r_fifo_inst [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]   r_fifo_pc   [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_CNT_W-1:0]    r_count;

    logic                  w_run;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_issue;
    logic [c_CNT_W:0]      w_credit;
    logic [PC_WIDTH-1:0]   w_target;

    function automatic logic [c_PTR_W-1:0] ptr_next(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign o_Inst_Valid = (r_count != '0);
    assign o_Inst       = r_fifo_inst[r_rd_ptr];
    assign o_Inst_PC    = r_fifo_pc[r_rd_ptr];
    assign o_Mem_Addr   = r_pc[MEM_ADDR_WIDTH+1:2];

    assign w_pop  = o_Inst_Valid & i_Inst_Ready;
    assign w_push = r_data_v & ~i_Redirect;

    // Slots already promised (buffered + in flight) net of this cycle's pop;
    // issuing only below the depth means a push can never overflow.
    assign w_credit  = {1'b0, r_count}
                     + {{c_CNT_W{1'b0}}, r_data_v}
                     - {{c_CNT_W{1'b0}}, w_pop};
    assign w_issue   = ~reset & w_run & ~i_Redirect & (w_credit < c_CREDIT_MAX);
    assign o_Mem_Req = w_issue;

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   r_misalign;
    logic   w_misaligned;

    assign w_misaligned = i_Redirect & (i_Redirect_PC[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_misalign <= w_misaligned;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (i_Redirect) begin
            w_state_next = w_misaligned ? ST_HALT : ST_RUN;
        end
    end

    assign w_run      = (r_state == ST_RUN);
    assign w_target   = i_Redirect_PC;
    assign o_Misalign = r_misalign;
`else
    assign w_run    = 1'b1;
    assign w_target = i_Redirect_PC & {{(PC_WIDTH-2){1'b1}}, 2'b00};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_data_v  <= 1'b0;
            r_data_pc <= '0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo_inst[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
        end else if (i_Redirect) begin
            // Buffered and in-flight words belong to the old stream.
            r_pc     <= w_target;
            r_data_v <= 1'b0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_data_v <= w_issue;
            if (w_issue) begin
                r_pc      <= r_pc + PC_WIDTH'(4);
                r_data_pc <= r_pc;
            end
            if (w_push) begin
                r_fifo_inst[r_wr_ptr] <= i_Mem_Data;
                r_fifo_pc[r_wr_ptr]   <= r_data_pc;
                r_wr_ptr              <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_ctrl
// Purpose  : Self-checking bench for inst_fetch_ctrl against a queue-based
//            reference model of the fetch stream (FETCH_MISALIGN_TRAP_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_ctrl;

    localparam int AW = 10;
    localparam int IW = 32;
    localparam int PW = 32;
    localparam logic [PW-1:0] RST_PC   = 32'h0000_0000;
    localparam logic [PW-1:0] RST_PC_W = 32'hFFFF_FFFC;
    localparam int VW = 1 + 1 + AW + PW + IW + 1;

    typedef logic [VW-1:0] vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] mem_addr, mem_addr_w;
    logic          mem_req, mem_req_w;
    logic [IW-1:0] mem_data, mem_data_w;
    logic          redirect;
    logic [PW-1:0] redirect_pc;
    logic          inst_valid, inst_valid_w;
    logic          inst_ready;
    logic [IW-1:0] inst, inst_w;
    logic [PW-1:0] inst_pc, inst_pc_w;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic          misalign, misalign_w;
`endif

    always #5 clk = ~clk;

    inst_fetch_ctrl #(.MEM_ADDR_WIDTH(AW), .INST_WIDTH(IW), .PC_WIDTH(PW),
                      .RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .o_Mem_Addr(mem_addr), .o_Mem_Req(mem_req), .i_Mem_Data(mem_data),
        .i_Redirect(redirect), .i_Redirect_PC(redirect_pc),
        .o_Inst_Valid(inst_valid), .i_Inst_Ready(inst_ready),
        .o_Inst(inst), .o_Inst_PC(inst_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        , .o_Misalign(misalign)
`endif
    );

    inst_fetch_ctrl #(.MEM_ADDR_WIDTH(AW), .INST_WIDTH(IW), .PC_WIDTH(PW),
                      .RESET_PC(RST_PC_W), .FIFO_DEPTH(2)) dut_w (
        .clk(clk), .reset(reset),
        .o_Mem_Addr(mem_addr_w), .o_Mem_Req(mem_req_w), .i_Mem_Data(mem_data_w),
        .i_Redirect(redirect), .i_Redirect_PC(redirect_pc),
        .o_Inst_Valid(inst_valid_w), .i_Inst_Ready(inst_ready),
        .o_Inst(inst_w), .o_Inst_PC(inst_pc_w)
`ifdef FETCH_MISALIGN_TRAP_EN
        , .o_Misalign(misalign_w)
`endif
    );

    function automatic logic [IW-1:0] memf(input logic [AW-1:0] a);
        return 32'h1000_0000 + 32'(a);
    endfunction

    // Synchronous-read instruction memories
    always @(posedge clk) begin
        mem_data   <= memf(mem_addr);
        mem_data_w <= memf(mem_addr_w);
    end

    int checks = 0;
    int errors = 0;

    // Reference model: next fetch PC, one in-flight read, queue of buffered PCs
    logic [PW-1:0] m_pc;
    logic          m_infl;
    logic [PW-1:0] m_infl_pc;
    logic [PW-1:0] m_q[$];
    logic          m_halt;
    logic          m_mis;

    logic          e_pop, e_valid, e_req, e_mis;
    logic [AW-1:0] e_addr;
    logic [PW-1:0] e_pc;
    logic [IW-1:0] e_inst;

    task automatic m_reset();
        m_q.delete();
        m_pc   = RST_PC;
        m_infl = 1'b0;
        m_halt = 1'b0;
        m_mis  = 1'b0;
    endtask

    task automatic model_expect();
        e_valid = (m_q.size() != 0);
        e_pop   = e_valid && inst_ready;
        e_req   = !m_halt && !redirect &&
                  ((m_q.size() + int'(m_infl) - int'(e_pop)) < 2);
        e_addr  = m_pc[AW+1:2];
        e_pc    = e_valid ? m_q[0] : {PW{1'b0}};
        e_inst  = e_valid ? memf(e_pc[AW+1:2]) : {IW{1'b0}};
        e_mis   = m_mis;
    endtask

    task automatic model_advance();
        if (e_pop) void'(m_q.pop_front());
        m_mis = 1'b0;
        if (redirect) begin
            m_q.delete();
            m_infl = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            m_halt = (redirect_pc[1:0] != 2'b00);
            m_mis  = m_halt;
            m_pc   = redirect_pc;
`else
            m_pc   = redirect_pc & ~32'd3;
`endif
        end else begin
            if (m_infl) m_q.push_back(m_infl_pc);
            m_infl = e_req;
            if (e_req) begin
                m_infl_pc = m_pc;
                m_pc      = m_pc + 32'd4;
            end
        end
    endtask

    function automatic vec_t exp_vec();
        return {e_valid, e_req, e_addr, e_pc, e_inst, e_mis};
    endfunction

    function automatic vec_t obs_vec();
        logic mis = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        mis = misalign;
`endif
        return {inst_valid, mem_req, mem_addr,
                inst_valid ? inst_pc : {PW{1'b0}},
                inst_valid ? inst    : {IW{1'b0}}, mis};
    endfunction

    task automatic drive(input logic rd, input logic [PW-1:0] tg, input logic rdy);
        redirect    = rd;
        redirect_pc = tg;
        inst_ready  = rdy;
    endtask

    task automatic tick();
        model_advance();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, '0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, '0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", inst_valid); end
        checks++;
        if (inst !== '0) begin errors++; $display("FAIL reset_inst got %h exp 0", inst); end
        checks++;
        if (inst_pc !== '0) begin errors++; $display("FAIL reset_inst_pc got %h exp 0", inst_pc); end
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", mem_req); end
        checks++;
        if (mem_addr !== RST_PC[AW+1:2]) begin errors++; $display("FAIL reset_addr got %h exp %h", mem_addr, RST_PC[AW+1:2]); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, '0, 1'b1);
            #1 model_expect();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stream cyc %0d got %h exp %h", i, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, '0, !(i >= 3 && i < 8));
            #1 model_expect();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL backpressure cyc %0d got %h exp %h", i, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(i == 6, 32'h0000_0040, (i != 5));
            #1 model_expect();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL redirect cyc %0d got %h exp %h", i, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b1);
            #1;
            if (i == 0) begin
                checks++;
                if ({inst_valid_w, mem_req_w, mem_addr_w} !== {1'b0, 1'b1, RST_PC_W[AW+1:2]}) begin
                    errors++;
                    $display("FAIL wrap_first got v=%b req=%b addr=%h exp v=0 req=1 addr=%h",
                             inst_valid_w, mem_req_w, mem_addr_w, RST_PC_W[AW+1:2]);
                end
            end
            if (i == 2) begin
                checks++;
                if ({inst_valid_w, inst_pc_w, inst_w} !== {1'b1, 32'hFFFF_FFFC, memf(10'h3FF)}) begin
                    errors++;
                    $display("FAIL wrap_top got v=%b pc=%h inst=%h exp v=1 pc=fffffffc inst=%h",
                             inst_valid_w, inst_pc_w, inst_w, memf(10'h3FF));
                end
            end
            if (i == 3) begin
                checks++;
                if ({inst_valid_w, inst_pc_w, inst_w} !== {1'b1, 32'h0000_0000, memf(10'h000)}) begin
                    errors++;
                    $display("FAIL wrap_zero got v=%b pc=%h inst=%h exp v=1 pc=00000000 inst=%h",
                             inst_valid_w, inst_pc_w, inst_w, memf(10'h000));
                end
            end
            model_expect();
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, '0, 1'b0);
            #1 model_expect();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid_fill cyc %0d got %h exp %h", i, obs_vec(), exp_vec());
            end
            tick();
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        #1;
        checks++;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_valid got %b exp 0", inst_valid); end
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, '0, 1'b1);
            #1 model_expect();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid_restart cyc %0d got %h exp %h", i, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_misalign();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive((i == 4) || (i == 10), (i == 4) ? 32'h0000_0042 : 32'h0000_0080, 1'b1);
            #1 model_expect();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL misalign cyc %0d got %h exp %h", i, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [PW-1:0] tg;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            tg = 32'($urandom_range(0, 255)) << 2;
            if ($urandom_range(0, 3) == 0) tg[1:0] = 2'($urandom_range(1, 3));
            drive($urandom_range(0, 19) == 0, tg, $urandom_range(0, 9) < 7);
            #1 model_expect();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d got %h exp %h", i, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, 1'b0);
        m_reset();
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_reset_mid();
        test_misalign();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
